// File: rtl/operand_prep_sb.sv
// operand_prep_sb
//   Register-address operand stage with write scoreboard. Extracts rs1/rs2/rd
//   from the instruction according to its decoded type, registers them in a
//   single valid/ready pipeline stage, and stalls issue while a source
//   register has an in-flight write (or the destination counter is full).
//
//   Optional feature: define OPERAND_PREP_BYPASS_EN so that a write retiring
//   in the current cycle is subtracted from the counters before the hazard
//   check (saves one stall cycle on a retiring source).
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   inst, type_PD        instruction word and decoded type (000 I .. 101 U)
//   in_valid, in_ready   input handshake
//   a1, a2, a3           registered rs1 / rs2 / rd addresses (0 when unused)
//   use1, use2, wr       a1/a2 are real operands, a3 will be written
//   out_valid, out_ready output handshake
//   wb_valid, wb_addr    writeback retiring one pending write

module operand_prep_sb #(
   parameter  int unsigned NREG   = 32,
   parameter  int unsigned PEND_W = 2,
   localparam int unsigned AW     = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   inst,
   input  logic [2:0]    type_PD,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [AW-1:0] a1,
   output logic [AW-1:0] a2,
   output logic [AW-1:0] a3,
   output logic          use1,
   output logic          use2,
   output logic          wr,
   output logic          out_valid,
   input  logic          out_ready,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_addr
);

   typedef enum logic [2:0] {
      T_I    = 3'b000,
      T_S    = 3'b001,
      T_R    = 3'b010,
      T_B    = 3'b011,
      T_J    = 3'b100,
      T_U    = 3'b101,
      T_ILL6 = 3'b110,
      T_ILL7 = 3'b111
   } inst_type_e;

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   inst_type_e        itype;
   logic [AW-1:0]     f_rs1, f_rs2, f_rd;
   logic              d_use1, d_use2, d_wrd, d_wr;
   logic [AW-1:0]     d_a1, d_a2, d_a3;
   logic              hazard, accept;
   logic [PEND_W-1:0] cnt     [NREG];
   logic [PEND_W-1:0] eff     [NREG];
   logic [NREG-1:0]   ret_hit;
   logic [NREG-1:0]   inc_hit;
   logic              unused_inst_bits;

   assign itype = inst_type_e'(type_PD);
   assign f_rs1 = AW'(inst[19:15]);
   assign f_rs2 = AW'(inst[24:20]);
   assign f_rd  = AW'(inst[11:7]);
   assign unused_inst_bits = ^{inst[31:25], inst[14:12], inst[6:0]};

   // Field decode; unused addresses are forced to 0.
   always_comb begin
      d_use1 = 1'b0;
      d_use2 = 1'b0;
      d_wrd  = 1'b0;
      case (itype)
         T_I:      begin d_use1 = 1'b1; d_wrd = 1'b1; end
         T_S, T_B: begin d_use1 = 1'b1; d_use2 = 1'b1; end
         T_R:      begin d_use1 = 1'b1; d_use2 = 1'b1; d_wrd = 1'b1; end
         T_J, T_U: begin d_wrd = 1'b1; end
         default:  ;
      endcase
      d_a1 = d_use1 ? f_rs1 : '0;
      d_a2 = d_use2 ? f_rs2 : '0;
      d_a3 = d_wrd  ? f_rd  : '0;
      d_wr = d_wrd && (f_rd != '0);
   end

   // A retire only counts against a non-zero counter; x0 never tracks.
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         ret_hit[r] = wb_valid && (wb_addr == AW'(r)) && (r != 0) && (cnt[r] != '0);
         inc_hit[r] = accept && d_wr && (d_a3 == AW'(r));
         eff[r]     = cnt[r];
`ifdef OPERAND_PREP_BYPASS_EN
         if (ret_hit[r]) eff[r] = cnt[r] - PEND_W'(1);
`endif
      end
   end

   assign hazard = (d_use1 && (eff[d_a1] != '0)) ||
                   (d_use2 && (eff[d_a2] != '0)) ||
                   (d_wr   && (eff[d_a3] == CNT_MAX));

   assign in_ready = !reset && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            if (inc_hit[r] && !ret_hit[r])
               cnt[r] <= cnt[r] + PEND_W'(1);
            else if (!inc_hit[r] && ret_hit[r])
               cnt[r] <= cnt[r] - PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         a1        <= '0;
         a2        <= '0;
         a3        <= '0;
         use1      <= 1'b0;
         use2      <= 1'b0;
         wr        <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         a1        <= d_a1;
         a2        <= d_a2;
         a3        <= d_a3;
         use1      <= d_use1;
         use2      <= d_use2;
         wr        <= d_wr;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
